// File: rtl/alu_pkg.sv
// Shared ALU types for the nibble-serial adder/subtractor.
package alu_pkg;

  localparam int unsigned NIBBLES = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned WORD_W  = NIBBLES * NIB_W;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } AluOp;

  typedef struct packed {
    AluOp op;
  } AluCtrl;

  // Nibble substituted for word2 above its explicitly-sized part.
  function automatic logic [NIB_W-1:0] ext_nibble(input logic negative);
    return negative ? '1 : '0;
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// 4-bit add/subtract slice; subtraction inverts b, the caller supplies the +1 as carry_in.
module nibble_adder
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  AluOp       op,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [3:0] b_eff;
  logic [4:0] total;

  // Operand conditioning and 5-bit sum
  always_comb begin
    b_eff     = (op == SUB) ? ~b : b;
    total     = {1'b0, a} + {1'b0, b_eff} + {4'b0000, carry_in};
    sum       = total[3:0];
    carry_out = total[4];
  end

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit adder/subtractor; processes only the nibbles needed and
// holds the caller with a combinational busy until the result is ready.
module loop_over_all_nibbles
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loop_perm_to_count,
  input  AluCtrl      ctrl,
  input  logic [2:0]  loop_nibbles_number,
  input  logic        word2_is_negative,
  input  logic [31:0] word1,
  input  logic [31:0] word2,
  input  logic [31:0] preinit_result,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state, state_next;
  logic [2:0]   idx, idx_next;
  logic         carry, carry_next;
  logic         done, done_next;
  logic [31:0]  result_next;

  logic [2:0]   cur_idx;
  logic [3:0]   ext;
  logic [3:0]   nib_a;
  logic [3:0]   nib_b;
  logic         nib_cin;
  logic [3:0]   nib_sum;
  logic         nib_cout;
  logic         last_nibble;
  logic [NIBBLES-1:0] nib_we;

  assign busy = loop_perm_to_count & ~done;

  // Operand nibble selection for the nibble handled on the coming edge
  always_comb begin
    cur_idx = (state == IDLE) ? 3'd0 : idx;
    ext     = ext_nibble(word2_is_negative);
    nib_a   = word1[{cur_idx, 2'b00} +: 4];
    nib_b   = (cur_idx <= loop_nibbles_number) ? word2[{cur_idx, 2'b00} +: 4] : ext;
    nib_cin = (state == IDLE) ? (ctrl.op == SUB) : carry;
  end

  nibble_adder u_nibble_adder (
    .a         (nib_a),
    .b         (nib_b),
    .op        (ctrl.op),
    .carry_in  (nib_cin),
    .sum       (nib_sum),
    .carry_out (nib_cout)
  );

  // Termination: ADD stops early once beyond the explicit part with nothing left to ripple
  always_comb begin
    last_nibble = (cur_idx == 3'd7);
    if (ctrl.op == ADD && cur_idx >= loop_nibbles_number && ext == 4'h0 && !nib_cout) begin
      last_nibble = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath update decisions
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    carry_next  = carry;
    done_next   = done;
    nib_we      = '0;
    result_next = result;

    case (state)
      IDLE: begin
        if (loop_perm_to_count) begin
          // Untouched nibbles must carry the preinit value, so load it whole first.
          result_next = preinit_result;
          nib_we[0]   = 1'b1;
          carry_next  = nib_cout;
          idx_next    = 3'd1;
          if (last_nibble) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!loop_perm_to_count) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b0;
        end else begin
          nib_we     = NIBBLES'(1) << cur_idx;
          carry_next = nib_cout;
          if (last_nibble) begin
            done_next  = 1'b1;
            state_next = DONE;
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      DONE: begin
        if (!loop_perm_to_count) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
        done_next  = 1'b0;
      end
    endcase

    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (nib_we[i]) begin
        result_next[i*NIB_W +: NIB_W] = nib_sum;
      end
    end
  end

  // Datapath registers: result, nibble index, carry, done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      done   <= 1'b0;
    end else begin
      result <= result_next;
      idx    <= idx_next;
      carry  <= carry_next;
      done   <= done_next;
    end
  end

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Testbench for loop_over_all_nibbles: vector table plus scoreboard, with
// hand-written reset-mid-op and permission-drop sequences.
module tb_loop_over_all_nibbles;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        loop_perm_to_count;
  AluCtrl      ctrl;
  logic [2:0]  loop_nibbles_number;
  logic        word2_is_negative;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] preinit_result;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    AluOp        op;
    logic [2:0]  n;
    logic        neg;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] pre;
    logic [31:0] exp_result;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          cycles;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[11];

  loop_over_all_nibbles dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .loop_perm_to_count  (loop_perm_to_count),
    .ctrl                (ctrl),
    .loop_nibbles_number (loop_nibbles_number),
    .word2_is_negative   (word2_is_negative),
    .word1               (word1),
    .word2               (word2),
    .preinit_result      (preinit_result),
    .result              (result),
    .busy                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input AluOp op, input logic [2:0] n,
                              input logic neg, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [31:0] pre, input logic [31:0] er, input int ec);
    vec_t v;
    v.name = name; v.op = op; v.n = n; v.neg = neg; v.w1 = w1; v.w2 = w2;
    v.pre = pre; v.exp_result = er; v.exp_cycles = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ctrl.op             = v.op;
    loop_nibbles_number = v.n;
    word2_is_negative   = v.neg;
    word1               = v.w1;
    word2               = v.w2;
    preinit_result      = v.pre;
  endtask

  task automatic run_op(input vec_t v);
    sb_t e;
    int  cyc;
    @(negedge clk);
    drive(v);
    loop_perm_to_count = 1'b1;
    sb.push_back('{v.name, v.exp_result, v.exp_cycles});
    #1;
    check({v.name, "_busy_first"}, {31'b0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e = sb.pop_front();
    check({e.name, "_result"}, result, e.res);
    check({e.name, "_cycles"}, cyc, e.cycles);
    @(posedge clk);
    #1;
    check({e.name, "_hold_result"}, result, e.res);
    check({e.name, "_hold_busy"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    loop_perm_to_count = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("pc_incr",   ADD, 3'd0, 1'b0, 32'h00000AEF, 32'h00000004, 32'h00000AEF, 32'h00000AF3, 2);
    vecs[1]  = mk("addi",      ADD, 3'd2, 1'b0, 32'h00000000, 32'h0000007B, 32'h00000000, 32'h0000007B, 3);
    vecs[2]  = mk("neg_imm",   ADD, 3'd2, 1'b1, 32'h00000005, 32'h00000FFE, 32'h00000005, 32'h00000003, 8);
    vecs[3]  = mk("wrap",      ADD, 3'd0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 8);
    vecs[4]  = mk("sub",       SUB, 3'd7, 1'b0, 32'h00000010, 32'h00000001, 32'h00000010, 32'h0000000F, 8);
    vecs[5]  = mk("one_nib",   ADD, 3'd0, 1'b0, 32'h11111111, 32'h00000002, 32'hABCDEF00, 32'hABCDEF03, 1);
    vecs[6]  = mk("sub_ext0",  SUB, 3'd0, 1'b0, 32'h00000100, 32'h00000001, 32'h00000000, 32'h000000FF, 8);
    vecs[7]  = mk("full_add",  ADD, 3'd7, 1'b0, 32'h12345678, 32'h11111111, 32'h00000000, 32'h23456789, 8);
    vecs[8]  = mk("w2_upper",  ADD, 3'd2, 1'b0, 32'h00000000, 32'hFFFFF123, 32'hDEADB000, 32'hDEADB123, 3);
    vecs[9]  = mk("ripple3",   ADD, 3'd0, 1'b0, 32'h000000FF, 32'h00000001, 32'h000000FF, 32'h00000100, 3);
    vecs[10] = mk("sub_neg",   SUB, 3'd2, 1'b1, 32'h00000005, 32'h00000FFE, 32'h00000000, 32'h00000007, 8);

    rst_n = 1'b0;
    loop_perm_to_count = 1'b0;
    drive(vecs[0]);
    #1;
    check("reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_result_hold", result, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i]);
    end

    // Asynchronous reset during the second busy cycle of the negative-immediate case
    @(negedge clk);
    drive(vecs[2]);
    loop_perm_to_count = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_result", result, 32'h0);
    loop_perm_to_count = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(vecs[2]);

    // Permission dropped mid-run, then a fresh operation
    @(negedge clk);
    drive(vecs[3]);
    loop_perm_to_count = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_running", {31'b0, busy}, 32'd1);
    @(negedge clk);
    loop_perm_to_count = 1'b0;
    #1;
    check("abort_busy_low", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    run_op(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
